// File: rtl/axi_apb_bridge_mc.sv
// AXI4-Lite slave to multi-slave APB master bridge with write/read alternation and DECERR decode.
// Optional PREADY watchdog is compiled in with `define APB_TIMEOUT_EN.
module axi_apb_bridge_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_prio_wr;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic                    r_bvalid;
  logic                    r_rvalid;
  logic [1:0]              r_bresp;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_in_idle;
  logic                    w_accept_wr;
  logic                    w_accept_rd;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_acc_addr;
  logic [SW-1:0]           w_acc_idx;
  logic                    w_acc_hit;
  logic [NUM_SLAVES-1:0]   w_acc_onehot;
  logic                    w_sel_pready;
  logic                    w_sel_pslverr;
  logic [DATA_WIDTH-1:0]   w_sel_prdata;
  logic [1:0]              w_rsp_code;
  logic                    w_timeout;
  logic                    w_done;

  // Ready is only offered from IDLE; the priority flag breaks a write/read tie.
  assign w_in_idle   = (r_state == S_IDLE) && !areset;
  assign w_accept_wr = w_in_idle && awvalid && wvalid && (r_prio_wr || !arvalid);
  assign w_accept_rd = w_in_idle && arvalid && !w_accept_wr;
  assign w_accept    = w_accept_wr || w_accept_rd;
  assign w_acc_addr  = w_accept_wr ? awaddr : araddr;
  assign w_acc_idx   = w_acc_addr[SEL_LSB +: SW];
  assign w_acc_hit   = ({1'b0, w_acc_idx} < (SW+1)'(NUM_SLAVES));

  // Decode of the accepted index and the selected slave's return signals.
  always_comb begin
    w_acc_onehot  = {NUM_SLAVES{1'b0}};
    w_sel_pready  = 1'b0;
    w_sel_pslverr = 1'b0;
    w_sel_prdata  = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_acc_onehot[i] = (w_acc_idx == SW'(i));
      w_sel_pready    = w_sel_pready  | (r_psel[i] & pready[i]);
      w_sel_pslverr   = w_sel_pslverr | (r_psel[i] & pslverr[i]);
      w_sel_prdata    = w_sel_prdata  |
                        ({DATA_WIDTH{r_psel[i]}} & prdata[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Counts ACCESS cycles spent without pready from the selected slave.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tmo_cnt <= {TW{1'b0}};
    end else if (r_state == S_SETUP) begin
      r_tmo_cnt <= {TW{1'b0}};
    end else if ((r_state == S_ACCESS) && !w_sel_pready) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // A pready in the final allowed cycle wins over the abort.
  assign w_timeout = (r_state == S_ACCESS) && !w_sel_pready &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES[0];
  assign w_timeout    = 1'b0;
`endif

  assign w_done = w_sel_pready || w_timeout;

  // Completion response; an abort reports SLVERR.
  always_comb begin
    if (w_sel_pready) begin
      w_rsp_code = w_sel_pslverr ? RESP_SLVERR : RESP_OKAY;
    end else begin
      w_rsp_code = RESP_SLVERR;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_acc_hit ? S_SETUP : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_done) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_RESP: begin
        if ((r_bvalid && bready) || (r_rvalid && rready)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered APB and AXI response outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_prio_wr <= 1'b1;
      r_psel    <= {NUM_SLAVES{1'b0}};
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= {ADDR_WIDTH{1'b0}};
      r_pwdata  <= {DATA_WIDTH{1'b0}};
      r_pstrb   <= {STRB_W{1'b0}};
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rresp   <= 2'b00;
      r_rdata   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_prio_wr <= !w_accept_wr;
            r_pwrite  <= w_accept_wr;
            r_paddr   <= w_acc_addr;
            r_pwdata  <= w_accept_wr ? wdata : {DATA_WIDTH{1'b0}};
            r_pstrb   <= w_accept_wr ? wstrb : {STRB_W{1'b0}};
            if (w_acc_hit) begin
              r_psel <= w_acc_onehot;
            end else if (w_accept_wr) begin
              r_bvalid <= 1'b1;
              r_bresp  <= RESP_DECERR;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= RESP_DECERR;
              r_rdata  <= {DATA_WIDTH{1'b0}};
            end
          end
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: begin
          if (w_done) begin
            r_psel    <= {NUM_SLAVES{1'b0}};
            r_penable <= 1'b0;
            if (r_pwrite) begin
              r_bvalid <= 1'b1;
              r_bresp  <= w_rsp_code;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= w_rsp_code;
              r_rdata  <= (w_rsp_code == RESP_OKAY) ? w_sel_prdata : {DATA_WIDTH{1'b0}};
            end
          end
        end
        S_RESP: begin
          if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
          end
          if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
          end
        end
        default: r_penable <= 1'b0;
      endcase
    end
  end

  assign awready = w_accept_wr;
  assign wready  = w_accept_wr;
  assign arready = w_accept_rd;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign pstrb   = r_pstrb;

endmodule

// File: tb/tb_axi_apb_bridge_mc.sv
// Directed bench for axi_apb_bridge_mc (three APB slaves so index 3 is unmapped).
module tb_axi_apb_bridge_mc;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;

  logic           aclk = 1'b0;
  logic           areset;
  logic [AW-1:0]  awaddr, araddr;
  logic           awvalid, wvalid, arvalid, bready, rready;
  logic [DW-1:0]  wdata;
  logic [3:0]     wstrb;
  logic           awready, wready, arready, bvalid, rvalid;
  logic [1:0]     bresp, rresp;
  logic [DW-1:0]  rdata;
  logic [NS-1:0]  psel;
  logic           penable, pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [3:0]     pstrb;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]  pready, pslverr;

  logic [7:0]     cur_waits;
  logic           cur_err;
  logic [31:0]    cur_data;
  logic [7:0]     wcnt;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_apb_bridge_mc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // APB slave model: selected slave answers after cur_waits ACCESS cycles;
  // unselected slaves drive ready/error/junk so wrong sampling shows up.
  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      pready[i]          = psel[i] ? (penable && (wcnt == cur_waits)) : 1'b1;
      pslverr[i]         = psel[i] ? cur_err : 1'b1;
      prdata[i*DW +: DW] = psel[i] ? cur_data : (32'h0BAD_0000 | 32'(i));
    end
  end

  always @(posedge aclk) begin
    if ((|psel) && penable && !(|(psel & pready))) wcnt <= wcnt + 8'd1;
    else wcnt <= 8'd0;
  end

  always @(negedge aclk) begin
    checks++;
    if (($countones(psel) > 1) || (penable && (psel == '0)) || (awready && arready)) begin
      failures++;
      $display("FAIL protocol: psel=%b penable=%b awready=%b arready=%b", psel, penable, awready, arready);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [7:0]  waits;
    logic        err;
    logic [31:0] sdata;
    int          rdly;
    logic [2:0]  e_psel;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input string tag);
    int   k;
    int   lat;
    logic acc;
    @(posedge aclk); #1;
    cur_waits = v.waits; cur_err = v.err; cur_data = v.sdata;
    if (v.wr) begin
      awaddr = v.addr; wdata = v.wdata; wstrb = v.strb; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = v.addr; arvalid = 1'b1;
    end
    acc = 1'b0; k = 0;
    while (!acc && k < 10) begin
      @(negedge aclk);
      acc = v.wr ? (awready && wready) : arready;
      k++;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk({tag, "_accept_cycles"}, k, 1);
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        chk({tag, "_setup_psel"}, psel, v.e_psel);
        chk({tag, "_setup_penable"}, penable, 0);
        if (v.e_psel != 3'b000) begin
          chk({tag, "_paddr"}, paddr, v.addr);
          chk({tag, "_pwrite"}, pwrite, v.wr);
          chk({tag, "_pstrb"}, pstrb, v.wr ? v.strb : 4'b0000);
          if (v.wr) chk({tag, "_pwdata"}, pwdata, v.wdata);
        end
      end
      if (v.wr ? bvalid : rvalid) lat = c;
    end
    chk({tag, "_latency"}, lat, v.e_lat);
    chk({tag, "_resp"}, v.wr ? bresp : rresp, v.e_resp);
    if (!v.wr) chk({tag, "_rdata"}, rdata, v.e_rdata);
    chk({tag, "_apb_idle"}, {psel, penable}, 0);
    for (int d = 0; d < v.rdly; d++) begin
      @(negedge aclk);
      chk({tag, "_valid_held"}, v.wr ? {bvalid, bresp} : {rvalid, rresp}, {1'b1, v.e_resp});
    end
    if (v.wr) bready = 1'b1; else rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    @(negedge aclk);
    chk({tag, "_valid_drop"}, v.wr ? bvalid : rvalid, 0);
  endtask

  initial begin
    logic        acc;
    logic        seen;
    logic [3:0]  ord;
    int          acyc[4];
    logic [1:0]  br[2];
    logic [1:0]  rr[2];
    logic [31:0] rd[2];
    int          k, nacc, nwr, nb, nr, cyc;

    vecs[0] = '{wr:1'b1, addr:32'h0000_1004, wdata:32'hA5A5_0001, strb:4'b0011, waits:8'd0,  err:1'b0,
                sdata:32'h0,         rdly:0, e_psel:3'b010, e_resp:2'b00, e_rdata:32'h0,         e_lat:3};
    vecs[1] = '{wr:1'b0, addr:32'h0000_2008, wdata:32'h0,         strb:4'b0000, waits:8'd3,  err:1'b0,
                sdata:32'hDEAD_BEEF, rdly:0, e_psel:3'b100, e_resp:2'b00, e_rdata:32'hDEAD_BEEF, e_lat:6};
    vecs[2] = '{wr:1'b0, addr:32'h0000_3000, wdata:32'h0,         strb:4'b0000, waits:8'd0,  err:1'b0,
                sdata:32'h5555_AAAA, rdly:0, e_psel:3'b000, e_resp:2'b11, e_rdata:32'h0,         e_lat:1};
    vecs[3] = '{wr:1'b1, addr:32'h0000_3010, wdata:32'h1234_0000, strb:4'b1111, waits:8'd0,  err:1'b0,
                sdata:32'h0,         rdly:1, e_psel:3'b000, e_resp:2'b11, e_rdata:32'h0,         e_lat:1};
    vecs[4] = '{wr:1'b0, addr:32'h0000_0004, wdata:32'h0,         strb:4'b0000, waits:8'd1,  err:1'b1,
                sdata:32'h1234_5678, rdly:0, e_psel:3'b001, e_resp:2'b10, e_rdata:32'h0,         e_lat:4};
    vecs[5] = '{wr:1'b1, addr:32'h8000_2FFC, wdata:32'h0BEE_F00D, strb:4'b1100, waits:8'd2,  err:1'b0,
                sdata:32'h0,         rdly:2, e_psel:3'b100, e_resp:2'b00, e_rdata:32'h0,         e_lat:5};
    vecs[6] = '{wr:1'b0, addr:32'h7FFF_100C, wdata:32'h0,         strb:4'b0000, waits:8'd15, err:1'b0,
                sdata:32'hCAFE_F00D, rdly:0, e_psel:3'b010, e_resp:2'b00, e_rdata:32'hCAFE_F00D, e_lat:18};
    vecs[7] = '{wr:1'b1, addr:32'h0000_0000, wdata:32'hFFFF_FFFF, strb:4'b1111, waits:8'd0,  err:1'b1,
                sdata:32'h0,         rdly:0, e_psel:3'b001, e_resp:2'b10, e_rdata:32'h0,         e_lat:3};
    vecs[8] = '{wr:1'b0, addr:32'h0000_1FF0, wdata:32'h0,         strb:4'b0000, waits:8'd0,  err:1'b0,
                sdata:32'h0000_00FF, rdly:0, e_psel:3'b010, e_resp:2'b00, e_rdata:32'h0000_00FF, e_lat:3};

    areset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    cur_waits = 8'd0; cur_err = 1'b0; cur_data = 32'h0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid, penable, pwrite, psel, bresp, rresp}, 0);
    chk("reset_data", {paddr, pwdata}, 0);
    chk("reset_misc", {pstrb, rdata}, 0);
    areset = 1'b0;

    // AW alone must not be accepted.
    @(posedge aclk); #1;
    awaddr = 32'h0000_1000; awvalid = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      if (awready || wready) seen = 1'b1;
    end
    chk("aw_without_w", seen, 0);
    @(posedge aclk); #1;
    awvalid = 1'b0;

`ifdef APB_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{wr:1'b1, addr:32'h0000_1020, wdata:32'h0000_0077, strb:4'b1111, waits:8'd255, err:1'b0,
             sdata:32'h0, rdly:0, e_psel:3'b010, e_resp:2'b10, e_rdata:32'h0, e_lat:18};
      run_vec(tv, "tmo_wr");
      tv = '{wr:1'b0, addr:32'h0000_2000, wdata:32'h0, strb:4'b0000, waits:8'd255, err:1'b0,
             sdata:32'h7777_7777, rdly:0, e_psel:3'b100, e_resp:2'b10, e_rdata:32'h0, e_lat:18};
      run_vec(tv, "tmo_rd");
    end
`endif

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while a write sits in ACCESS: everything clears, no response.
    @(posedge aclk); #1;
    cur_waits = 8'd200; cur_err = 1'b0;
    awaddr = 32'h0000_1000; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    acc = 1'b0; k = 0;
    while (!acc && k < 10) begin
      @(negedge aclk);
      acc = awready && wready;
      k++;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rst_accept", acc, 1);
    k = 0;
    while (!penable && k < 10) begin
      @(negedge aclk);
      k++;
    end
    chk("rst_reach_access", penable, 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("rst_mid_ctrl", {awready, wready, arready, bvalid, rvalid, penable, pwrite, psel, bresp, rresp}, 0);
    chk("rst_mid_data", {paddr, pwdata}, 0);
    chk("rst_mid_misc", {pstrb, rdata}, 0);
    @(negedge aclk);
    areset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge aclk);
      if (bvalid || rvalid || (|psel)) seen = 1'b1;
    end
    chk("rst_no_resp", seen, 0);

    // All three valids held: alternation W,R,W,R at one accept per 4 cycles.
    @(posedge aclk); #1;
    cur_waits = 8'd0; cur_err = 1'b0; cur_data = 32'h1111_2222;
    awaddr = 32'h0000_0040; wdata = 32'h0000_00AA; wstrb = 4'hF; araddr = 32'h0000_0080;
    bready = 1'b1; rready = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    ord = 4'b0000; nacc = 0; nwr = 0; nb = 0; nr = 0; cyc = 0;
    for (int i = 0; i < 4; i++) acyc[i] = 0;
    while ((nb < 2 || nr < 2) && cyc < 80) begin
      @(negedge aclk);
      if (awready && wready && nacc < 4) begin
        ord[nacc] = 1'b1; acyc[nacc] = cyc; nacc++; nwr++;
        cur_err = (nwr == 2);
      end else if (arready && nacc < 4) begin
        ord[nacc] = 1'b0; acyc[nacc] = cyc; nacc++;
        cur_err = 1'b0;
      end
      if (bvalid && nb < 2) begin br[nb] = bresp; nb++; end
      if (rvalid && nr < 2) begin rr[nr] = rresp; rd[nr] = rdata; nr++; end
      @(posedge aclk); #1;
      cyc++;
      if (nacc >= 4) begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    chk("arb_count", nacc, 4);
    chk("arb_order", ord, 4'b0101);
    for (int i = 0; i < 3; i++) chk($sformatf("arb_period%0d", i), acyc[i+1] - acyc[i], 4);
    chk("arb_resp_count", {nb[3:0], nr[3:0]}, {4'd2, 4'd2});
    chk("arb_bresp0", br[0], 2'b00);
    chk("arb_bresp1", br[1], 2'b10);
    chk("arb_rresp", {rr[0], rr[1]}, 4'b0000);
    chk("arb_rdata0", rd[0], 32'h1111_2222);
    chk("arb_rdata1", rd[1], 32'h1111_2222);

    repeat (3) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_apb_bridge_mc.md
# axi_apb_bridge_mc

Parametrised AXI4-Lite slave to APB3/APB4 master bridge with multi-slave decode. It serves NUM_SLAVES APB peripherals (UART APB bridge, timers, GPIO) from one AXI-Lite master. Over the single-slave bridge it adds:
- per-slave PSEL decode
- PSTRB forwarding
- PSLVERR to SLVERR mapping
- DECERR for unmapped addresses
- fair read/write arbitration
- an optional PREADY timeout

## Interface
- ADDR_WIDTH, 32, AXI/APB address width
- DATA_WIDTH, 32, data width; 8, 16 or 32 only; strobe width DATA_WIDTH/8
- NUM_SLAVES, 4, APB slave count, 1..16
- SEL_LSB, 12, LSB of the slave-index field; field width SW = max(1, $clog2(NUM_SLAVES))
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort (APB_TIMEOUT_EN only), ≥2

Ports (one clock, `aclk`; reset `areset` is synchronous and active-high):
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  write strobes
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  B handshake
- araddr  in  ADDR_WIDTH  read address
- arvalid / arready  in / out  1  AR handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  R handshake
- psel  out  NUM_SLAVES  one-hot APB select
- penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- pready, pslverr  in  NUM_SLAVES  per-slave status

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, write candidate: awvalid && wvalid are both high. AW and W are accepted only together; awready = wready = 1 for exactly the accept cycle.
- IDLE, read candidate: arvalid high; arready = 1 for the accept cycle.
- Both candidates present: the priority flag decides. After reset write wins. After each served transaction the flag points to the other direction.
- On accept, the bridge latches address, wdata, wstrb and direction, then computes idx = addr[SEL_LSB +: SW].
- idx < NUM_SLAVES: go to SETUP.
- idx ≥ NUM_SLAVES: go to RESP with DECERR (2'b11). No APB access is made.
- SETUP: psel[idx] = 1, penable = 0, paddr/pwrite/pwdata driven; pstrb = wstrb on writes, 0 on reads. Next state is ACCESS.
- ACCESS: penable = 1. The bridge waits for pready[idx].
  - On pready[idx]: response is SLVERR (2'b10) if pslverr[idx], else OKAY (2'b00). A successful read latches prdata slice idx.
  - Then go to RESP; psel and penable drop to 0 that same edge.
- RESP: bvalid or rvalid is held, with resp and data stable, until bready/rready. Then go to IDLE.
- rdata = 0 on any non-OKAY read.
- Only pready/pslverr/prdata of the selected slave are sampled; other slaves' inputs are ignored.
- Upper address bits outside the index field are passed through unchanged on paddr.
- Reset, including mid-transaction:
  - FSM returns to IDLE and the in-flight transaction is dropped with no response.
  - Priority flag resets to write.
  - Every output is 0: all ready/valid, psel, penable, pwrite, paddr, pwdata, pstrb, rdata, bresp, rresp.

## Timing
- Accept at edge T. SETUP at T+1, ACCESS from T+2.
- Zero-wait slave (pready = 1 in the first ACCESS cycle): bvalid/rvalid high from T+3.
- Each wait cycle adds 1 cycle.
- DECERR response is valid from T+1.
- One transaction is outstanding at a time. No address or handshake ready is asserted outside IDLE.
- Back-to-back: bready/rready high in the first RESP cycle means IDLE in the next cycle, and the next accept can happen there. Minimum period is 4 cycles per zero-wait transfer.
- psel is never asserted for two slaves at once. penable is never high without psel.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without pready[idx].
  - At TIMEOUT_CYCLES the access aborts: psel/penable drop, response is SLVERR, rdata = 0, then go to RESP.
  - A pready arriving in the same cycle as the abort wins, and completes normally.
- APB_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely.

## Test plan
- Write 0xA5A5_0001, addr 0x0000_1004, wstrb 4'b0011, slave 1 zero-wait -> psel = 4'b0010 at T+1, pstrb = 4'b0011, bvalid at T+3 with bresp = 00.
- Read addr 0x0000_2008, slave 2 returning 0xDEAD_BEEF after 3 wait cycles -> rvalid at T+6, rdata = 0xDEAD_BEEF, rresp = 00.
- NUM_SLAVES = 3, read addr 0x0000_3000 -> no psel, rvalid at T+1, rresp = 11, rdata = 0.
- awvalid, wvalid and arvalid held together for 4 transfers -> order W, R, W, R; zero-wait slave 0 on pslverr = 1 for the second write -> bresp = 10.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never raises pready -> psel drops after 16 ACCESS cycles, bresp = 10; second run asserts areset in ACCESS -> all outputs 0 next cycle and no bvalid.
